// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects and extends load data or ALU result,
// suppresses misaligned loads and counts retired instructions.
module mem_wb_stage #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              mem_valid_i,
   input  logic              mem_writeEnable_i,
   input  logic [4:0]        mem_writeAddr_i,
   input  logic [DATA_W-1:0] mem_aluResult_i,
   input  logic [2:0]        mem_loadOp_i,
   input  logic [DATA_W-1:0] mem_loadData_i,
   output logic              writeEnable_o,
   output logic [4:0]        writeAddr_o,
   output logic [DATA_W-1:0] writeData_o,
   output logic              loadError_o,
   output logic [DATA_W-1:0] badAddr_o,
   output logic [CNT_W-1:0]  retired_o
);

   localparam logic [2:0] LD_B  = 3'b001;
   localparam logic [2:0] LD_BU = 3'b010;
   localparam logic [2:0] LD_H  = 3'b011;
   localparam logic [2:0] LD_HU = 3'b100;
   localparam logic [2:0] LD_W  = 3'b101;

   logic [1:0]        lane;
   logic              op_b;
   logic              op_h;
   logic              op_w;
   logic              sgn;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic              misaligned;
   logic [DATA_W-1:0] result;
   logic              advance;

   assign lane    = mem_aluResult_i[1:0];
   assign advance = ~flush_i & ~stall_i;

   // Classify the load op; 110/111 fall through to "no load".
   always_comb begin
      op_b = (mem_loadOp_i == LD_B) | (mem_loadOp_i == LD_BU);
      op_h = (mem_loadOp_i == LD_H) | (mem_loadOp_i == LD_HU);
      op_w = (mem_loadOp_i == LD_W);
      sgn  = (mem_loadOp_i == LD_B) | (mem_loadOp_i == LD_H);
   end

   // Little-endian byte and halfword lane extraction.
   always_comb begin
      ld_byte = mem_loadData_i[7:0];
      unique case (lane)
         2'd0: ld_byte = mem_loadData_i[7:0];
         2'd1: ld_byte = mem_loadData_i[15:8];
         2'd2: ld_byte = mem_loadData_i[23:16];
         2'd3: ld_byte = mem_loadData_i[31:24];
         default: ld_byte = mem_loadData_i[7:0];
      endcase
      ld_half = lane[1] ? mem_loadData_i[31:16]
                        : mem_loadData_i[15:0];
   end

   // Halfwords need even addresses, words need 4-byte alignment.
   always_comb begin
      misaligned = (op_h & lane[0]) | (op_w & (lane != 2'b00));
   end

   // Writeback value mux with sign/zero extension.
   always_comb begin
      result = mem_aluResult_i;
      unique case (1'b1)
         op_b: result = {{(DATA_W-8){sgn & ld_byte[7]}}, ld_byte};
         op_h: result = {{(DATA_W-16){sgn & ld_half[15]}}, ld_half};
         op_w: result = mem_loadData_i;
         default: result = mem_aluResult_i;
      endcase
   end

   // Regfile write port registers; flush loads a bubble, stall holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         writeEnable_o <= 1'b0;
         writeAddr_o   <= '0;
         writeData_o   <= '0;
      end else if (flush_i) begin
         writeEnable_o <= 1'b0;
         writeAddr_o   <= '0;
         writeData_o   <= '0;
      end else if (!stall_i) begin
         writeEnable_o <= mem_valid_i & mem_writeEnable_i & ~misaligned;
         writeAddr_o   <= mem_writeAddr_i;
         writeData_o   <= result;
      end
   end

   // Misaligned-load pulse; cleared on stall so it never repeats.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         loadError_o <= 1'b0;
      end else if (advance) begin
         loadError_o <= mem_valid_i & misaligned;
      end else begin
         loadError_o <= 1'b0;
      end
   end

   // Capture the address of the most recent suppressed load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         badAddr_o <= '0;
      end else if (advance && mem_valid_i && misaligned) begin
         badAddr_o <= mem_aluResult_i;
      end
   end

   // Retired counter: every valid instruction entering WB, wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retired_o <= '0;
      end else if (advance && mem_valid_i) begin
         retired_o <= retired_o + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage against a behavioural model.
// Uses CNT_W=4 so counter wrap is reachable.
module tb_mem_wb_stage;

   localparam int CW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        flush;
   logic        valid;
   logic        wen;
   logic [4:0]  waddr;
   logic [31:0] alu;
   logic [2:0]  op;
   logic [31:0] ldata;
   logic        we_q;
   logic [4:0]  addr_q;
   logic [31:0] data_q;
   logic        err_q;
   logic [31:0] bad_q;
   logic [CW-1:0] ret_q;

   int checks = 0;
   int errors = 0;

   bit          m_we;
   bit [4:0]    m_addr;
   bit [31:0]   m_data;
   bit          m_err;
   bit [31:0]   m_bad;
   int          m_ret;

   mem_wb_stage #(.DATA_W(32), .CNT_W(CW)) dut (
      .clk               (clk),
      .rst               (rst),
      .stall_i           (stall),
      .flush_i           (flush),
      .mem_valid_i       (valid),
      .mem_writeEnable_i (wen),
      .mem_writeAddr_i   (waddr),
      .mem_aluResult_i   (alu),
      .mem_loadOp_i      (op),
      .mem_loadData_i    (ldata),
      .writeEnable_o     (we_q),
      .writeAddr_o       (addr_q),
      .writeData_o       (data_q),
      .loadError_o       (err_q),
      .badAddr_o         (bad_q),
      .retired_o         (ret_q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic bit [31:0] ref_value(input bit [2:0] o,
                                           input bit [31:0] a,
                                           input bit [31:0] d);
      int unsigned sh;
      bit [31:0] v;
      case (o)
         3'd1, 3'd2: begin
            sh = 8 * (a % 4);
            v = (d >> sh) & 32'hFF;
            if (o == 3'd1 && v >= 128) v = v | 32'hFFFF_FF00;
            return v;
         end
         3'd3, 3'd4: begin
            sh = ((a % 4) >= 2) ? 16 : 0;
            v = (d >> sh) & 32'hFFFF;
            if (o == 3'd3 && v >= 32768) v = v | 32'hFFFF_0000;
            return v;
         end
         3'd5: return d;
         default: return a;
      endcase
   endfunction

   function automatic bit ref_mis(input bit [2:0] o, input bit [31:0] a);
      if (o == 3'd3 || o == 3'd4) return (a % 2) != 0;
      if (o == 3'd5) return (a % 4) != 0;
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_we = 0; m_addr = 0; m_data = 0;
      m_err = 0; m_bad = 0; m_ret = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".we"},   32'(we_q),   32'(m_we));
      chk({tag, ".addr"}, 32'(addr_q), 32'(m_addr));
      chk({tag, ".data"}, data_q,      m_data);
      chk({tag, ".err"},  32'(err_q),  32'(m_err));
      chk({tag, ".bad"},  bad_q,       m_bad);
      chk({tag, ".ret"},  32'(ret_q),  32'(m_ret));
   endtask

   task automatic tick(input string tag);
      bit mis;
      if (flush) begin
         m_we = 0; m_addr = 0; m_data = 0; m_err = 0;
      end else if (stall) begin
         m_err = 0;
      end else begin
         mis = ref_mis(op, alu);
         m_we = valid && wen && !mis;
         m_addr = waddr;
         m_data = ref_value(op, alu, ldata);
         m_err = valid && mis;
         if (valid && mis) m_bad = alu;
         if (valid) m_ret = (m_ret + 1) % (1 << CW);
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic drive(input bit v, input bit w, input bit [4:0] a,
                        input bit [31:0] r, input bit [2:0] o,
                        input bit [31:0] d);
      valid = v; wen = w; waddr = a; alu = r; op = o; ldata = d;
   endtask

   task automatic rand_drive();
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            5'($urandom), $urandom, 3'($urandom), $urandom);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_reset();
      check_all("rst");
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; stall = 0; flush = 0;
      drive(0, 0, 0, 0, 0, 0);
      model_reset();
      #1;
      check_all("por");
      @(negedge clk);
      rst = 1'b0;

      // mid-stream asynchronous reset
      drive(1, 1, 5'd9, 32'hCAFE_0001, 3'd0, 0);
      tick("pre");
      chk("pre.we1", 32'(we_q), 32'd1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all("async");
      @(negedge clk);
      rst = 1'b0;
      drive(1, 1, 5'd5, 32'h0000_1234, 3'd0, 0);
      tick("first");
      chk("first.data", data_q, 32'h0000_1234);
      chk("first.ret", 32'(ret_q), 32'd1);

      // load extraction
      drive(1, 1, 5'd1, 32'h3, 3'd1, 32'h80FF_7F01); tick("lb3");
      chk("lb3.k", data_q, 32'hFFFF_FF80);
      drive(1, 1, 5'd1, 32'h3, 3'd2, 32'h80FF_7F01); tick("lbu3");
      chk("lbu3.k", data_q, 32'h0000_0080);
      drive(1, 1, 5'd1, 32'h0, 3'd1, 32'h80FF_7F01); tick("lb0");
      chk("lb0.k", data_q, 32'h0000_0001);
      drive(1, 1, 5'd1, 32'h2, 3'd3, 32'h80FF_7F01); tick("lh2");
      chk("lh2.k", data_q, 32'hFFFF_80FF);
      drive(1, 1, 5'd1, 32'h0, 3'd4, 32'h80FF_7F01); tick("lhu0");
      chk("lhu0.k", data_q, 32'h0000_7F01);
      drive(1, 1, 5'd1, 32'h4, 3'd5, 32'h80FF_7F01); tick("lw");
      chk("lw.k", data_q, 32'h80FF_7F01);

      // misaligned loads
      drive(1, 1, 5'd2, 32'h1000_0002, 3'd5, $urandom); tick("mlw");
      chk("mlw.err", 32'(err_q), 32'd1);
      chk("mlw.bad", bad_q, 32'h1000_0002);
      drive(1, 1, 5'd2, 32'h1000_0001, 3'd3, $urandom); tick("mlh");
      chk("mlh.we", 32'(we_q), 32'd0);
      chk("mlh.bad", bad_q, 32'h1000_0001);
      drive(0, 0, 5'd0, 32'h0, 3'd0, 0); tick("mend");
      chk("mend.err", 32'(err_q), 32'd0);

      // stall holds for three cycles while inputs churn
      drive(1, 1, 5'd12, 32'h1111_2222, 3'd0, 0); tick("prestall");
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_drive();
         tick("stall");
      end
      chk("stall.ret", 32'(ret_q), 32'(m_ret));
      chk("stall.data", data_q, 32'h1111_2222);
      stall = 1'b0;
      drive(1, 1, 5'd13, 32'h3333_4444, 3'd0, 0); tick("unstall");

      // flush beats stall
      stall = 1'b1; flush = 1'b1;
      drive(1, 1, 5'd7, 32'h7777_7777, 3'd0, 0); tick("flush");
      chk("flush.addr", 32'(addr_q), 32'd0);
      stall = 1'b0; flush = 1'b0;

      // counter wrap after reset and bubbles not counted
      do_reset();
      for (int i = 0; i < 17; i++) begin
         drive(1, 1, 5'($urandom), $urandom, 3'd0, 0);
         tick("wrap");
      end
      chk("wrap.ret", 32'(ret_q), 32'd1);
      drive(0, 1, 5'd3, 32'h55, 3'd0, 0); tick("bubble");
      chk("bubble.we", 32'(we_q), 32'd0);
      chk("bubble.ret", 32'(ret_q), 32'd1);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         rand_drive();
         if ($urandom_range(0, 3) == 0) alu[1:0] = 2'b00;
         stall = ($urandom_range(0, 7) == 0);
         flush = ($urandom_range(0, 9) == 0);
         tick("rnd");
      end
      stall = 0; flush = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline boundary of the MIPS32 core. Sits directly upstream of the register file and drives its write port (writeEnable, writeAddr, writeData).
- Selects the writeback value: either the ALU result or load data with byte/halfword extraction and sign/zero extension. Registers it for one cycle.
- Handles stall, flush and misaligned-load suppression. Keeps a retired-instruction counter.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- stall_i  in  1  1 = hold all stage registers.
- flush_i  in  1  1 = load a bubble; has priority over stall_i.
- mem_valid_i  in  1  MEM stage holds a real instruction.
- mem_writeEnable_i  in  1  instruction writes a GPR.
- mem_writeAddr_i  in  5  destination GPR.
- mem_aluResult_i  in  32  ALU result; also the load effective address.
- mem_loadOp_i  in  3  load type: 000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW; 110/111 treated as none.
- mem_loadData_i  in  32  raw aligned word from data memory.
- writeEnable_o  out  1  to regfile writeEnable_i.
- writeAddr_o  out  5  to regfile writeAddr_i.
- writeData_o  out  32  to regfile writeData_i.
- loadError_o  out  1  one-cycle pulse: a misaligned load was suppressed.
- badAddr_o  out  32  address of the last misaligned load.
- retired_o  out  CNT_W  count of instructions that entered WB.

Behaviour:
- Reset (asynchronous, rst=1): writeEnable_o=0, writeAddr_o=0, writeData_o=0, loadError_o=0, badAddr_o=0, retired_o=0. Outputs stay at these values while rst=1.
- Latency: exactly 1 cycle. MEM inputs sampled on rising edge N appear on the outputs after edge N.
- Priority per edge, highest first: rst, flush_i, stall_i, normal update.
- flush_i=1:
  - writeEnable_o=0, writeAddr_o=0, writeData_o=0, loadError_o=0.
  - badAddr_o holds; retired_o does not increment.
- stall_i=1 (and flush_i=0):
  - All registers hold, including retired_o.
  - loadError_o is cleared to 0, so the pulse never repeats.
  - A held writeEnable_o=1 rewrites the same value each cycle. This is idempotent and legal.
- Normal update, no stall and no flush:
  - writeAddr_o <= mem_writeAddr_i.
  - writeData_o <= result, where result = extracted load data when loadOp ∈ {LB, LBU, LH, LHU, LW}, else mem_aluResult_i.
  - writeEnable_o <= mem_valid_i & mem_writeEnable_i & ~misaligned.
  - retired_o <= retired_o + 1 when mem_valid_i=1. Wraps modulo 2^CNT_W; a misaligned load still counts.
  - loadError_o <= mem_valid_i & misaligned. When that is 1, badAddr_o <= mem_aluResult_i.
- Byte lanes are little-endian, with a = mem_aluResult_i[1:0]:
  - LB/LBU: byte = loadData[8a+7:8a]; LB sign-extends bit 7, LBU zero-extends.
  - LH/LHU: half = loadData[15:0] when a[1]=0, else loadData[31:16]; sign- or zero-extended from bit 15.
  - LW: whole word.
- misaligned = (LH or LHU, and a[0]=1) or (LW, and a≠00). LB/LBU are never misaligned.
- writeAddr=0 passes through unchanged. The regfile ignores writes to r0; this block does not special-case it.
- A bubble (mem_valid_i=0) forces writeEnable_o=0. writeAddr_o and writeData_o still load, and are don't-care.
- Regfile read-during-write bypass depends on these outputs being registered and glitch-free. All outputs come directly from flops.
- rst asserted mid-stall or mid-flush clears everything immediately, with no clock edge required.

Test Plan:
- Reset mid-stream: with writeEnable_o=1, raise rst between clock edges -> all outputs 0 immediately. After release, the first valid ALU op (addr 5, alu 0x0000_1234) -> writeEnable_o=1, writeAddr_o=5, writeData_o=0x1234 one cycle later; retired_o=1.
- Load extraction, loadData=0x80FF_7F01:
  - LB a=3 -> 0xFFFF_FF80; LBU a=3 -> 0x0000_0080; LB a=0 -> 0x0000_0001.
  - LH a=2 -> 0xFFFF_80FF; LHU a=0 -> 0x0000_7F01; LW -> 0x80FF_7F01.
- Misaligned loads: LW with address 0x1000_0002, or LH with address 0x1000_0001 -> writeEnable_o=0, loadError_o=1 for exactly one cycle, badAddr_o=that address, retired_o incremented.
- Stall: assert stall_i 3 cycles while the inputs change -> outputs frozen at the previous values, retired_o unchanged, loadError_o=0 during the stall. Release -> the next instruction appears one cycle later.
- Flush beats stall: stall_i=1 and flush_i=1 in the same cycle with a valid write to r7 -> writeEnable_o=0, writeAddr_o=0, writeData_o=0, retired_o unchanged.
- Counter wrap with CNT_W=4: 17 valid instructions -> retired_o=1. Bubbles (mem_valid_i=0) with mem_writeEnable_i=1 -> writeEnable_o=0 and no count.
